// File: rtl/fifo_enqueue_adapter_pkg.sv
// Shared types and constants for the FIFO enqueue adapter.
// State encoding and default statistics counter width.
package fifo_enqueue_adapter_pkg;

   typedef enum logic [0:0] {PASS, SKID} enq_state_t;

   localparam int STAT_W = 32;

endpackage

// File: rtl/fifo_enqueue_adapter_sat_counter.sv
// Enabled up-counter that sticks at all-ones.
// Synchronous active-low reset clears it to zero.
module sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk) begin
      if (!rst) begin
         count <= '0;
      end else if (en && (count != {WIDTH{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/fifo_enqueue_adapter.sv
// Producer-side front end for the core FIFO: valid/ready in, push/potential_push out,
// with a one-entry skid so in_ready is a flop. Optional counters under FIFO_ENQ_STATS_EN.
module fifo_enqueue_adapter
   import fifo_enqueue_adapter_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int STAT_WIDTH = STAT_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  fifo_full,
   input  logic                  fifo_pop,
   output logic                  fifo_push,
   output logic                  fifo_potential_push,
   output logic [DATA_WIDTH-1:0] fifo_data_in,
   output logic [STAT_WIDTH-1:0] stat_accepted,
   output logic [STAT_WIDTH-1:0] stat_stall
);

   enq_state_t            state;
   enq_state_t            next_state;
   logic [DATA_WIDTH-1:0] skid;
   logic                  can_push;
   logic                  hs;
   logic                  src_valid;
   logic [DATA_WIDTH-1:0] src_data;

   // A pop in the same cycle frees a slot, so full-and-draining still accepts.
   assign can_push = ~fifo_full | fifo_pop;
   assign hs       = in_valid & in_ready;

   always_comb begin
      src_valid  = 1'b0;
      src_data   = in_data;
      next_state = state;
      unique case (state)
         PASS: begin
            src_valid  = hs;
            src_data   = in_data;
            next_state = (hs && !can_push) ? SKID : PASS;
         end
         SKID: begin
            src_valid  = 1'b1;
            src_data   = skid;
            next_state = can_push ? PASS : SKID;
         end
         default: next_state = PASS;
      endcase
      if (flush) begin
         next_state = PASS;
      end
   end

   // Gated by rst so a stale SKID state cannot push while reset is held.
   assign fifo_potential_push = rst & src_valid & can_push;
   assign fifo_push           = fifo_potential_push & ~flush;
   assign fifo_data_in        = src_data;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= PASS;
         in_ready <= 1'b0;
      end else begin
         state    <= next_state;
         in_ready <= (next_state == PASS) & ~flush;
      end
   end

   always_ff @(posedge clk) begin
      if (state == PASS && hs && !can_push && !flush) begin
         skid <= in_data;
      end
   end

`ifdef FIFO_ENQ_STATS_EN
   sat_counter #(.WIDTH(STAT_WIDTH)) u_stat_accepted (
      .clk   (clk),
      .rst   (rst),
      .en    (hs),
      .count (stat_accepted)
   );

   sat_counter #(.WIDTH(STAT_WIDTH)) u_stat_stall (
      .clk   (clk),
      .rst   (rst),
      .en    (state == SKID),
      .count (stat_stall)
   );
`else
   assign stat_accepted = '0;
   assign stat_stall    = '0;
`endif

endmodule

// File: tb/tb_fifo_enqueue_adapter.sv
// Scoreboard bench for fifo_enqueue_adapter: expected pushes are queued by stimulus
// and retired by a negedge monitor. Stat expectations follow FIFO_ENQ_STATS_EN.
module tb_fifo_enqueue_adapter;

   localparam int DW = 32;
   localparam int SW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          fifo_full;
   logic          fifo_pop;
   logic          fifo_push;
   logic          fifo_potential_push;
   logic [DW-1:0] fifo_data_in;
   logic [SW-1:0] stat_accepted;
   logic [SW-1:0] stat_stall;

   int            tests_run    = 0;
   int            tests_failed = 0;
   logic [DW-1:0] exp_q[$];

   fifo_enqueue_adapter #(.DATA_WIDTH(DW), .STAT_WIDTH(SW)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .flush               (flush),
      .in_valid            (in_valid),
      .in_ready            (in_ready),
      .in_data             (in_data),
      .fifo_full           (fifo_full),
      .fifo_pop            (fifo_pop),
      .fifo_push           (fifo_push),
      .fifo_potential_push (fifo_potential_push),
      .fifo_data_in        (fifo_data_in),
      .stat_accepted       (stat_accepted),
      .stat_stall          (stat_stall)
   );

   always #5 clk = ~clk;

`ifdef FIFO_ENQ_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   function automatic logic [63:0] stat_exp(input int n);
      return STATS ? 64'(n) : 64'd0;
   endfunction

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic apply_stimulus(input logic v, input logic [DW-1:0] d, input logic full,
                                 input logic pop, input logic fl, input bit expect_push);
      in_valid  = v;
      in_data   = d;
      fifo_full = full;
      fifo_pop  = pop;
      flush     = fl;
      if (expect_push) exp_q.push_back(d);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic mid_cycle();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      next_cycle();
      rst = 1'b1;
      next_cycle();
   endtask

   // Monitor: every committed push must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (fifo_push === 1'b1) begin
         if (exp_q.size() == 0) begin
            check_output("unexpected_push", 64'(fifo_data_in), 64'hDEAD_0000);
         end else begin
            check_output("push_data", 64'(fifo_data_in), 64'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation did not finish, got 1, expected 0");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      rst = 1'b0;
      apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

      // 1. Reset
      for (int i = 0; i < 3; i++) begin
         mid_cycle();
         check_output("reset_in_ready", 64'(in_ready), 64'd0);
         check_output("reset_push", 64'(fifo_push), 64'd0);
         next_cycle();
      end
      rst = 1'b1;
      mid_cycle();
      check_output("release_in_ready_before_edge", 64'(in_ready), 64'd0);
      next_cycle();
      mid_cycle();
      check_output("release_in_ready", 64'(in_ready), 64'd1);
      check_output("reset_stat_accepted", 64'(stat_accepted), 64'd0);
      check_output("reset_stat_stall", 64'(stat_stall), 64'd0);
      next_cycle();

      // 2. Passthrough
      apply_stimulus(1'b1, 32'h11, 1'b0, 1'b0, 1'b0, 1'b1);
      next_cycle();
      apply_stimulus(1'b1, 32'h22, 1'b0, 1'b0, 1'b0, 1'b1);
      next_cycle();
      apply_stimulus(1'b1, 32'h33, 1'b0, 1'b0, 1'b0, 1'b1);
      mid_cycle();
      check_output("pass_push", 64'(fifo_push), 64'd1);
      next_cycle();
      apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      mid_cycle();
      check_output("pass_in_ready", 64'(in_ready), 64'd1);
      check_output("pass_stat_accepted", 64'(stat_accepted), stat_exp(3));
      next_cycle();

      // 3. Skid capture, held three cycles in SKID
      do_reset();
      apply_stimulus(1'b1, 32'hAA, 1'b1, 1'b0, 1'b0, 1'b0);
      mid_cycle();
      check_output("skid_capture_ready", 64'(in_ready), 64'd1);
      next_cycle();
      apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      mid_cycle();
      check_output("skid_in_ready", 64'(in_ready), 64'd0);
      next_cycle();
      mid_cycle();
      check_output("skid_hold_ready", 64'(in_ready), 64'd0);
      next_cycle();
      apply_stimulus(1'b0, 32'hAA, 1'b0, 1'b0, 1'b0, 1'b1);
      in_data = '0;
      mid_cycle();
      check_output("skid_release_push", 64'(fifo_push), 64'd1);
      next_cycle();
      mid_cycle();
      check_output("skid_ready_after", 64'(in_ready), 64'd1);
      check_output("skid_stat_stall", 64'(stat_stall), stat_exp(3));
      check_output("skid_stat_accepted", 64'(stat_accepted), stat_exp(1));
      next_cycle();

      // 4. Full with pop every cycle: full-rate streaming, never SKID
      do_reset();
      for (int i = 1; i <= 8; i++) begin
         apply_stimulus(1'b1, 32'(i), 1'b1, 1'b1, 1'b0, 1'b1);
         mid_cycle();
         check_output("fullpop_ready", 64'(in_ready), 64'd1);
         next_cycle();
      end
      apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      mid_cycle();
      check_output("fullpop_stat_stall", 64'(stat_stall), 64'd0);
      check_output("fullpop_stat_accepted", 64'(stat_accepted), stat_exp(8));
      next_cycle();

      // 5. Flush while SKID holds 0x55
      do_reset();
      apply_stimulus(1'b1, 32'h55, 1'b1, 1'b0, 1'b0, 1'b0);
      next_cycle();
      apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      mid_cycle();
      check_output("flush_push", 64'(fifo_push), 64'd0);
      check_output("flush_potential_push", 64'(fifo_potential_push), 64'd1);
      check_output("flush_data", 64'(fifo_data_in), 64'h55);
      next_cycle();
      apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      mid_cycle();
      check_output("flush_ready_low", 64'(in_ready), 64'd0);
      check_output("flush_no_push", 64'(fifo_push), 64'd0);
      next_cycle();
      mid_cycle();
      check_output("flush_ready_high", 64'(in_ready), 64'd1);
      next_cycle();
      // Handshake during flush in PASS is accepted and dropped
      apply_stimulus(1'b1, 32'h77, 1'b0, 1'b0, 1'b1, 1'b0);
      mid_cycle();
      check_output("flush_pass_potential", 64'(fifo_potential_push), 64'd1);
      next_cycle();
      apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      mid_cycle();
      check_output("flush_pass_ready_low", 64'(in_ready), 64'd0);
      next_cycle();
      apply_stimulus(1'b1, 32'h66, 1'b0, 1'b0, 1'b0, 1'b1);
      next_cycle();
      apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Reset while SKID is occupied: entry lost, no push
      do_reset();
      apply_stimulus(1'b1, 32'h99, 1'b1, 1'b0, 1'b0, 1'b0);
      next_cycle();
      rst = 1'b0;
      apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      mid_cycle();
      check_output("reset_skid_push", 64'(fifo_push), 64'd0);
      next_cycle();
      rst = 1'b1;
      next_cycle();
      mid_cycle();
      check_output("reset_skid_ready", 64'(in_ready), 64'd1);
      next_cycle();

      // 6. Saturation of the accepted counter
      do_reset();
      for (int i = 0; i < 20; i++) begin
         apply_stimulus(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b1);
         next_cycle();
      end
      apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      mid_cycle();
      check_output("sat_stat_accepted", 64'(stat_accepted), stat_exp(15));
      check_output("sat_stat_stall", 64'(stat_stall), 64'd0);
      next_cycle();
      next_cycle();

      check_output("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
